// File: rtl/ws_frame_sched_if.sv
// Pixel write, commit and sender handshake bundle for ws_frame_sched.
// The slave modport is the scheduler side; master is the producer/sender side.
interface ws_frame_sched_if #(
  parameter int WS_NUM = 16,
  parameter int ADDR_W = (WS_NUM > 1) ? $clog2(WS_NUM) : 1
);
  logic                    a_req;
  logic [ADDR_W-1:0]       a_addr;
  logic [23:0]             a_color;
  logic                    a_gnt;
  logic                    b_req;
  logic [ADDR_W-1:0]       b_addr;
  logic [23:0]             b_color;
  logic                    b_gnt;
  logic                    commit;
  logic                    send_busy;
  logic                    send_start;
  logic [24*WS_NUM-1:0]    wscolor;
  logic [15:0]             frame_cnt;
  logic                    overrun;

  modport slave (
    input  a_req, a_addr, a_color, b_req, b_addr, b_color, commit, send_busy,
    output a_gnt, b_gnt, send_start, wscolor, frame_cnt, overrun
  );

  modport master (
    output a_req, a_addr, a_color, b_req, b_addr, b_color, commit, send_busy,
    input  a_gnt, b_gnt, send_start, wscolor, frame_cnt, overrun
  );
endinterface

// File: rtl/ws_frame_sched.sv
// WS2812 frame scheduler: round-robin shadow-buffer writes, periodic shadow->active
// copy and sender frame tracking. Define WS_SCHED_AUTOCOMMIT_EN to copy on every frame.
module ws_frame_sched #(
  parameter logic [31:0] CLKHZ    = 32'd50_000_000,
  parameter logic [31:0] FRAME_HZ = 32'd30,
  parameter int          WS_NUM   = 16
) (
  input  logic              external_clk,
  input  logic              external_rstn,
  ws_frame_sched_if.slave   bus
);

  localparam int          ADDR_W    = (WS_NUM > 1) ? $clog2(WS_NUM) : 1;
  localparam logic [31:0] TICK_LAST = (CLKHZ / FRAME_HZ) - 32'd1;
  localparam logic        WIN_A     = 1'b0;
  localparam logic        WIN_B     = 1'b1;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_SWAP  = 3'd1,
    S_START = 3'd2,
    S_ACK   = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           tick_cnt_q, tick_cnt_d;
  logic                  tick_s;
  logic                  last_win_q, last_win_d;
  logic [23:0]           shadow_q [WS_NUM];
  logic [23:0]           shadow_d [WS_NUM];
  logic [24*WS_NUM-1:0]  active_q, active_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  commit_pend_q, commit_pend_d;
  logic                  send_start_q, send_start_d;
  logic                  a_gnt_s, b_gnt_s, wr_en_s, copy_s;
  logic [ADDR_W-1:0]     wr_addr_s;
  logic [23:0]           wr_color_s;

  // Compared at 32 bits so an index that can exceed the pixel count is caught.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return ({{(32-ADDR_W){1'b0}}, addr} < 32'(WS_NUM));
  endfunction

  // Round-robin grant: on contention the requester that did not win last time goes.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    if (bus.a_req && bus.b_req) begin
      a_gnt_s = (last_win_q == WIN_B);
      b_gnt_s = (last_win_q == WIN_A);
    end else begin
      a_gnt_s = bus.a_req;
      b_gnt_s = bus.b_req;
    end
  end

  // Winning write selection and round-robin history update.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = bus.a_addr;
    wr_color_s = bus.a_color;
    last_win_d = last_win_q;
    if (a_gnt_s) begin
      wr_en_s    = addr_ok(bus.a_addr);
      last_win_d = WIN_A;
    end else if (b_gnt_s) begin
      wr_addr_s  = bus.b_addr;
      wr_color_s = bus.b_color;
      wr_en_s    = addr_ok(bus.b_addr);
      last_win_d = WIN_B;
    end else begin
      wr_en_s    = 1'b0;
    end
  end

  // Free-running refresh divider.
  always_comb begin
    tick_s     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_s ? 32'd0 : (tick_cnt_q + 32'd1);
  end

  // Frame FSM next state and copy strobe.
  always_comb begin
    state_d = state_q;
    copy_s  = 1'b0;
    case (state_q)
      S_WAIT:  state_d = tick_s ? S_SWAP : S_WAIT;
      S_SWAP: begin
`ifdef WS_SCHED_AUTOCOMMIT_EN
        copy_s  = 1'b1;
`else
        copy_s  = commit_pend_q || bus.commit;
`endif
        state_d = S_START;
      end
      S_START: state_d = S_ACK;
      S_ACK:   state_d = bus.send_busy ? S_BUSY : S_ACK;
      S_BUSY:  state_d = bus.send_busy ? S_BUSY : S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Buffers, counters and flags; a tick outside S_WAIT is only recorded as overrun.
  always_comb begin
    for (int i = 0; i < WS_NUM; i++) begin
      shadow_d[i] = (wr_en_s && (wr_addr_s == ADDR_W'(i))) ? wr_color_s : shadow_q[i];
      active_d[24*i +: 24] = copy_s ? shadow_q[i] : active_q[24*i +: 24];
    end
    send_start_d = (state_d == S_START);
    frame_cnt_d  = (state_q == S_START) ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    overrun_d    = overrun_q | (tick_s && (state_q != S_WAIT));
`ifdef WS_SCHED_AUTOCOMMIT_EN
    commit_pend_d = 1'b0;
`else
    if (bus.commit) begin
      commit_pend_d = 1'b1;
    end else if (state_q == S_SWAP) begin
      commit_pend_d = 1'b0;
    end else begin
      commit_pend_d = commit_pend_q;
    end
`endif
  end

  // Control state registers.
  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      state_q       <= S_WAIT;
      tick_cnt_q    <= 32'd0;
      last_win_q    <= WIN_B;
      frame_cnt_q   <= 16'd0;
      overrun_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      send_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      last_win_q    <= last_win_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      commit_pend_q <= commit_pend_d;
      send_start_q  <= send_start_d;
    end
  end

  // Shadow and active pixel buffers.
  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      for (int i = 0; i < WS_NUM; i++) begin
        shadow_q[i] <= 24'd0;
      end
      active_q <= '0;
    end else begin
      for (int i = 0; i < WS_NUM; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      active_q <= active_d;
    end
  end

  assign bus.a_gnt      = a_gnt_s;
  assign bus.b_gnt      = b_gnt_s;
  assign bus.send_start = send_start_q;
  assign bus.wscolor    = active_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.overrun    = overrun_q;

endmodule
